// File: rtl/mfp_mul_sched_if.sv
// -----------------------------------------------------------------------------
// mfp_mul_sched_if
// Bundles the request and result handshakes of the shared multiplier
// scheduler.
//
//   req_valid [NREQ]       requester i presents an operand pair
//   req_ready [NREQ]       requester i is accepted this cycle (one-hot or zero)
//   req_a     [NREQ*In1W]  operand A, requester i at [i*In1W +: In1W]
//   req_b     [NREQ*In2W]  operand B, requester i at [i*In2W +: In2W]
//   res_valid              result present
//   res_ready              result consumer accepts
//   res_id    [IDW]        requester index the result belongs to
//   res_data  [OutW]       rounded product
//   busy                   some pipeline stage holds a valid entry
//
// master = requesters plus result consumer (the environment).
// slave  = the scheduler.
// -----------------------------------------------------------------------------
interface mfp_mul_sched_if #(
    parameter int NREQ = 4,
    parameter int In1W = 8,
    parameter int In2W = 8,
    parameter int OutW = 8,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*In1W-1:0] req_a;
    logic [NREQ*In2W-1:0] req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [IDW-1:0]       res_id;
    logic [OutW-1:0]      res_data;
    logic                 busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_id, res_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_data, busy
    );
endinterface

// File: rtl/mfp_mul_sched.sv
// -----------------------------------------------------------------------------
// mfp_mul_sched
// Round-robin scheduler sharing one pipelined signed fixed-point multiplier
// among NREQ requesters. At most one request is granted per cycle; it flows
// through stage 0 (operand capture), stage 1 (multiply + round/saturate) and
// LAT-1 further delay stages, so a grant at edge k shows res_valid after edge
// k+LAT. Results leave in grant order, tagged with the requester index.
// A single advance signal stalls every stage (and blocks grants) while the
// output holds a result the consumer has not taken.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of mfp_mul_sched_if (request/result handshakes, busy)
//
// Parameters:
//   NREQ      number of requesters (2..16)
//   In1W/In2W signed operand widths
//   OutW      result width, less than In1W+In2W-1
//   LAT       grant-to-result latency in cycles (1..8)
//   isFloor   1 = truncate, 0 = round half-up on the first dropped bit
//   Saturate  1 = symmetric saturation when rounding
//   IDW       result tag width
// -----------------------------------------------------------------------------
module mfp_mul_sched #(
    parameter int NREQ     = 4,
    parameter int In1W     = 8,
    parameter int In2W     = 8,
    parameter int OutW     = 8,
    parameter int LAT      = 2,
    parameter bit isFloor  = 1'b1,
    parameter bit Saturate = 1'b0,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic           clk,
    input  logic           rst_n,
    mfp_mul_sched_if.slave bus
);

    localparam int PW = In1W + In2W;       // full product width
    localparam int RW = In1W + In2W - 1;   // kept width, duplicate sign dropped

    localparam logic [OutW-1:0] MIN_NEG = {1'b1, {(OutW-1){1'b0}}};
    localparam logic [OutW-1:0] MAX_POS = {1'b0, {(OutW-1){1'b1}}};
    localparam logic [OutW-1:0] SYM_NEG = {1'b1, {(OutW-2){1'b0}}, 1'b1};

    // Multiply, drop the duplicate sign bit, then truncate or round.
    // The only product needing bit RW is (-max)*(-max); it wraps by design.
    // Saturation: the sole way T reaches the most negative code is either a
    // positive overflow of the round-up add or that wrapped product, so the
    // sign of the truncated value picks which symmetric limit replaces it.
    function automatic logic [OutW-1:0] f_mul_round(
        input logic signed [In1W-1:0] a,
        input logic signed [In2W-1:0] b
    );
        logic signed [PW-1:0] prod;
        logic [OutW-1:0]      trunc;
        logic                 rbit;
        logic [OutW-1:0]      t;
        prod  = $signed({{In2W{a[In1W-1]}}, a}) * $signed({{In1W{b[In2W-1]}}, b});
        trunc = OutW'(prod >>> (RW - OutW));
        rbit  = prod[RW-OutW-1];
        if (isFloor) begin
            t = trunc;
        end else begin
            t = trunc + {{(OutW-1){1'b0}}, rbit};
            if (Saturate && (t == MIN_NEG)) begin
                t = trunc[OutW-1] ? SYM_NEG : MAX_POS;
            end
        end
        return t;
    endfunction

    logic [IDW-1:0]          r_last;
    logic [LAT:0]            r_vld;
    logic [IDW-1:0]          r_id [LAT+1];
    logic signed [In1W-1:0]  r_a_p0;
    logic signed [In2W-1:0]  r_b_p0;
    logic [OutW-1:0]         r_dat [1:LAT];
    logic                    r_busy;

    logic                    w_adv;
    logic                    w_any;
    logic                    w_hi_any;
    logic [IDW-1:0]          w_lo_win;
    logic [IDW-1:0]          w_hi_win;
    logic [IDW-1:0]          w_win;
    logic [NREQ-1:0]         w_grant;
    logic signed [In1W-1:0]  w_a;
    logic signed [In2W-1:0]  w_b;
    logic [LAT:0]            w_vld_nxt;

    // A full output that is not being taken freezes the whole pipe.
    assign w_adv = !r_vld[LAT] || bus.res_ready;

    // Rotating priority: the lowest valid index above r_last wins; if none,
    // the search wraps and the lowest valid index overall wins. Scanning
    // downward and overwriting leaves the lowest match in each winner.
    always_comb begin
        w_any    = 1'b0;
        w_hi_any = 1'b0;
        w_lo_win = '0;
        w_hi_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                w_any    = 1'b1;
                w_lo_win = IDW'(k);
                if (IDW'(k) > r_last) begin
                    w_hi_any = 1'b1;
                    w_hi_win = IDW'(k);
                end
            end
        end
        w_win = w_hi_any ? w_hi_win : w_lo_win;
    end

    // Ready is purely a function of valids, stall state and priority pointer;
    // it is held low while reset is asserted.
    assign w_grant = (w_adv && w_any && rst_n) ? (NREQ'(1) << w_win) : '0;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == w_win) begin
                w_a = bus.req_a[k*In1W +: In1W];
                w_b = bus.req_b[k*In2W +: In2W];
            end
        end
    end

    always_comb begin
        w_vld_nxt    = '0;
        w_vld_nxt[0] = w_any;
        for (int i = 1; i <= LAT; i++) begin
            w_vld_nxt[i] = r_vld[i-1];
        end
    end

    // Stage 0: grant capture of {valid, id, a, b}; pointer update.
    // Valid/id shift in lock-step with the data stages below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= IDW'(NREQ - 1);
            r_vld  <= '0;
            r_id   <= '{default: '0};
            r_a_p0 <= '0;
            r_b_p0 <= '0;
            r_busy <= 1'b0;
        end else if (w_adv) begin
            r_vld  <= w_vld_nxt;
            r_busy <= |w_vld_nxt;
            if (w_any) begin
                r_last <= w_win;
                r_id[0] <= w_win;
                r_a_p0  <= w_a;
                r_b_p0  <= w_b;
            end
            for (int i = 1; i <= LAT; i++) begin
                r_id[i] <= r_id[i-1];
            end
        end
    end

    // Stage 1: multiply and round; stages 2..LAT: delay to the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dat <= '{default: '0};
        end else if (w_adv) begin
            r_dat[1] <= f_mul_round(r_a_p0, r_b_p0);
            for (int i = 2; i <= LAT; i++) begin
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.res_valid = r_vld[LAT];
    assign bus.res_id    = r_id[LAT];
    assign bus.res_data  = r_dat[LAT];
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mfp_mul_sched.sv
// -----------------------------------------------------------------------------
// tb_mfp_mul_sched
// Three scheduler instances (floor; round+saturate; round+wrap) share one set
// of request/result stimulus. A negedge monitor keeps a transaction model of
// the round-robin grant and the LAT-deep pipe, pushes each grant to a
// scoreboard and compares every produced result against it. Scenario tasks
// add their own direct checks against literal expectations.
// -----------------------------------------------------------------------------
module tb_mfp_mul_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        res_ready;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] a;
        logic [7:0] b;
    } sb_t;

    sb_t        sb_q[$];
    logic [2:0] m_vld  = '0;
    int         m_last = 3;

    mfp_mul_sched_if #(.NREQ(4), .In1W(8), .In2W(8), .OutW(8)) if_f ();
    mfp_mul_sched_if #(.NREQ(4), .In1W(8), .In2W(8), .OutW(8)) if_r ();
    mfp_mul_sched_if #(.NREQ(4), .In1W(8), .In2W(8), .OutW(8)) if_w ();

    assign if_f.req_valid = req_valid;
    assign if_f.req_a     = req_a;
    assign if_f.req_b     = req_b;
    assign if_f.res_ready = res_ready;
    assign if_r.req_valid = req_valid;
    assign if_r.req_a     = req_a;
    assign if_r.req_b     = req_b;
    assign if_r.res_ready = res_ready;
    assign if_w.req_valid = req_valid;
    assign if_w.req_a     = req_a;
    assign if_w.req_b     = req_b;
    assign if_w.res_ready = res_ready;

    mfp_mul_sched #(.NREQ(4), .In1W(8), .In2W(8), .OutW(8), .LAT(LAT),
                    .isFloor(1'b1), .Saturate(1'b0))
        u_floor (.clk(clk), .rst_n(rst_n), .bus(if_f.slave));
    mfp_mul_sched #(.NREQ(4), .In1W(8), .In2W(8), .OutW(8), .LAT(LAT),
                    .isFloor(1'b0), .Saturate(1'b1))
        u_rsat (.clk(clk), .rst_n(rst_n), .bus(if_r.slave));
    mfp_mul_sched #(.NREQ(4), .In1W(8), .In2W(8), .OutW(8), .LAT(LAT),
                    .isFloor(1'b0), .Saturate(1'b0))
        u_rwrap (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic on integers: only 0x80*0x80 exceeds the kept 15
    // bits and wraps to -16384; rounding is half-up on the scaled value.
    function automatic logic [7:0] exp_val(input logic [7:0] a, input logic [7:0] b,
                                           input bit floor_m, input bit sat);
        int p;
        int r;
        p = int'($signed(a)) * int'($signed(b));
        if (p == 16384) p = -16384;
        if (floor_m) r = p >>> 7;
        else         r = (p + 64) >>> 7;
        if (sat && !floor_m) begin
            if (r > 127)   r = 127;
            if (r == -128) r = -127;
        end
        return r[7:0];
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        sb_t        e;
        logic [3:0] exp_rdy;
        bit         m_adv;
        bit         m_any;
        int         m_win;
        int         j;
        if (!rst_n) begin
            sb_q.delete();
            m_vld  = '0;
            m_last = 3;
            n_checks++;
            if (if_f.req_ready !== 4'b0 || if_f.res_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL mon_in_reset: ready=%b res_valid=%b, required ready=0000 res_valid=0",
                         if_f.req_ready, if_f.res_valid);
            end
        end else begin
            n_checks++;
            if (if_f.res_valid !== m_vld[2] || if_r.res_valid !== m_vld[2] ||
                if_w.res_valid !== m_vld[2]) begin
                n_errors++;
                $display("FAIL mon_res_valid: got f=%b r=%b w=%b, required %b",
                         if_f.res_valid, if_r.res_valid, if_w.res_valid, m_vld[2]);
            end
            n_checks++;
            if (if_f.busy !== (|m_vld)) begin
                n_errors++;
                $display("FAIL mon_busy: got %b, required %b", if_f.busy, |m_vld);
            end
            if (m_vld[2]) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL mon_sb_empty: result present with no expected entry");
                end else begin
                    e = sb_q[0];
                    if (if_f.res_id !== e.id || if_f.res_data !== exp_val(e.a, e.b, 1'b1, 1'b0)) begin
                        n_errors++;
                        $display("FAIL sb_floor: got id=%0d data=%h, required id=%0d data=%h (a=%h b=%h)",
                                 if_f.res_id, if_f.res_data, e.id, exp_val(e.a, e.b, 1'b1, 1'b0), e.a, e.b);
                    end
                    n_checks++;
                    if (if_r.res_id !== e.id || if_r.res_data !== exp_val(e.a, e.b, 1'b0, 1'b1)) begin
                        n_errors++;
                        $display("FAIL sb_round_sat: got id=%0d data=%h, required id=%0d data=%h (a=%h b=%h)",
                                 if_r.res_id, if_r.res_data, e.id, exp_val(e.a, e.b, 1'b0, 1'b1), e.a, e.b);
                    end
                    n_checks++;
                    if (if_w.res_id !== e.id || if_w.res_data !== exp_val(e.a, e.b, 1'b0, 1'b0)) begin
                        n_errors++;
                        $display("FAIL sb_round_wrap: got id=%0d data=%h, required id=%0d data=%h (a=%h b=%h)",
                                 if_w.res_id, if_w.res_data, e.id, exp_val(e.a, e.b, 1'b0, 1'b0), e.a, e.b);
                    end
                    if (res_ready) void'(sb_q.pop_front());
                end
            end
            m_adv = !m_vld[2] || res_ready;
            m_any = 1'b0;
            m_win = 0;
            if (m_adv) begin
                for (int k = 1; k <= NREQ; k++) begin
                    j = (m_last + k) % NREQ;
                    if (!m_any && req_valid[j]) begin
                        m_any = 1'b1;
                        m_win = j;
                    end
                end
            end
            exp_rdy = m_any ? (4'b0001 << m_win) : 4'b0000;
            n_checks++;
            if (if_f.req_ready !== exp_rdy || if_r.req_ready !== exp_rdy ||
                if_w.req_ready !== exp_rdy) begin
                n_errors++;
                $display("FAIL mon_req_ready: got f=%b r=%b w=%b, required %b",
                         if_f.req_ready, if_r.req_ready, if_w.req_ready, exp_rdy);
            end
            if (m_adv) begin
                m_vld = {m_vld[1:0], m_any};
                if (m_any) begin
                    e.id = 2'(m_win);
                    e.a  = req_a[m_win*8 +: 8];
                    e.b  = req_b[m_win*8 +: 8];
                    sb_q.push_back(e);
                    m_last = m_win;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic send(input int idx, input logic [7:0] a, input logic [7:0] b);
        bit got;
        got = 1'b0;
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
        req_valid[idx]    = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (if_f.req_ready[idx]) got = 1'b1;
        end
        tick();
        req_valid[idx] = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL send_timeout: req %0d ready=0, required 1 within 50 cycles", idx);
        end
    endtask

    task automatic drain();
        req_valid = '0;
        res_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (sb_q.size() == 0 && !if_f.res_valid && !if_f.busy) break;
            tick();
        end
        n_checks++;
        if (sb_q.size() != 0 || if_f.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL drain: pending=%0d busy=%b, required 0 and 0", sb_q.size(), if_f.busy);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #1 rst_n  = 1'b0;
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (if_f.res_valid !== 1'b0 || if_r.res_valid !== 1'b0 || if_w.res_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_res_valid: got %b%b%b, required 000",
                     if_f.res_valid, if_r.res_valid, if_w.res_valid);
        end
        n_checks++;
        if (if_f.res_id !== 2'd0 || if_f.res_data !== 8'h00 || if_r.res_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_res_fields: id=%0d data=%h/%h, required 0 and 00",
                     if_f.res_id, if_f.res_data, if_r.res_data);
        end
        n_checks++;
        if (if_f.busy !== 1'b0 || if_f.req_ready !== 4'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy=%b ready=%b, required 0 and 0000",
                     if_f.busy, if_f.req_ready);
        end
        req_valid = '0;
        rst_n     = 1'b1;
        tick();
    endtask

    task automatic test_fairness();
        req_a     = $urandom;
        req_b     = $urandom;
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (if_f.req_ready !== (4'b0001 << (k % 4))) begin
                n_errors++;
                $display("FAIL rr_grant[%0d]: got %b, required %b", k, if_f.req_ready,
                         4'b0001 << (k % 4));
            end
            if (k >= 3) begin
                n_checks++;
                if (if_f.res_valid !== 1'b1 || if_f.res_id !== 2'((k - 3) % 4)) begin
                    n_errors++;
                    $display("FAIL rr_res_id[%0d]: got valid=%b id=%0d, required 1 and %0d",
                             k, if_f.res_valid, if_f.res_id, (k - 3) % 4);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_arith();
        logic [7:0] ta [4] = '{8'h40, 8'h7F, 8'h01, 8'h80};
        logic [7:0] tb [4] = '{8'h40, 8'h7F, 8'h40, 8'h80};
        logic [7:0] ef [4] = '{8'h20, 8'h7E, 8'h00, 8'h80};
        logic [7:0] er [4] = '{8'h20, 8'h7E, 8'h01, 8'h81};
        logic [7:0] ew [4] = '{8'h20, 8'h7E, 8'h01, 8'h80};
        bit seen;
        for (int i = 0; i < 4; i++) begin
            send(0, ta[i], tb[i]);
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (if_f.res_valid) seen = 1'b1;
            end
            n_checks++;
            if (!seen || if_f.res_data !== ef[i] || if_r.res_data !== er[i] ||
                if_w.res_data !== ew[i]) begin
                n_errors++;
                $display("FAIL arith[%0d] a=%h b=%h: got valid=%b f=%h r=%h w=%h, required 1 %h %h %h",
                         i, ta[i], tb[i], seen, if_f.res_data, if_r.res_data, if_w.res_data,
                         ef[i], er[i], ew[i]);
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            send(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end
        send(2, 8'h80, 8'h7F);
        send(1, 8'h7F, 8'h80);
        drain();
    endtask

    task automatic test_sparse();
        req_a     = $urandom;
        req_b     = $urandom;
        res_ready = 1'b1;
        req_valid = 4'b1000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (if_f.req_ready !== 4'b1000) begin
                n_errors++;
                $display("FAIL sparse_only3[%0d]: got %b, required 1000", k, if_f.req_ready);
            end
            tick();
        end
        req_valid = 4'b1010;
        @(negedge clk);
        n_checks++;
        if (if_f.req_ready !== 4'b0010) begin
            n_errors++;
            $display("FAIL rotate_first: got %b, required 0010", if_f.req_ready);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (if_f.req_ready !== 4'b1000) begin
            n_errors++;
            $display("FAIL rotate_second: got %b, required 1000", if_f.req_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        bit g;
        res_ready       = 1'b1;
        req_a[23:16]    = 8'($urandom);
        req_b[23:16]    = 8'($urandom);
        req_valid       = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            g = if_f.req_ready[2];
            tick();
            if (g) begin
                req_a[23:16] = 8'($urandom);
                req_b[23:16] = 8'($urandom);
            end
        end
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (if_f.res_valid !== 1'b1 || if_f.res_id !== 2'd2 || if_f.req_ready !== 4'b0) begin
                n_errors++;
                $display("FAIL stall[%0d]: got valid=%b id=%0d ready=%b, required 1 2 0000",
                         k, if_f.res_valid, if_f.res_id, if_f.req_ready);
            end
            tick();
        end
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            g = if_f.req_ready[2];
            if (k == 0) begin
                n_checks++;
                if (g !== 1'b1) begin
                    n_errors++;
                    $display("FAIL release_grant: got ready[2]=%b, required 1", g);
                end
            end
            tick();
            if (g) begin
                req_a[23:16] = 8'($urandom);
                req_b[23:16] = 8'($urandom);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        req_a     = $urandom;
        req_b     = $urandom;
        req_valid = 4'b0011;
        @(negedge clk);
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        tick();
        req_valid = 4'b0000;
        n_checks++;
        if (if_f.busy !== 1'b1 || if_f.res_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL inflight: got busy=%b res_valid=%b, required 1 and 0",
                     if_f.busy, if_f.res_valid);
        end
        #2 rst_n = 1'b0;
        req_valid = 4'hF;
        #1;
        n_checks++;
        if (if_f.res_valid !== 1'b0 || if_f.res_id !== 2'd0 || if_f.res_data !== 8'h00 ||
            if_f.busy !== 1'b0 || if_f.req_ready !== 4'b0) begin
            n_errors++;
            $display("FAIL async_reset: got valid=%b id=%0d data=%h busy=%b ready=%b, required 0 0 00 0 0000",
                     if_f.res_valid, if_f.res_id, if_f.res_data, if_f.busy, if_f.req_ready);
        end
        tick();
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (if_f.res_valid !== 1'b0 || if_r.res_valid !== 1'b0 || if_w.res_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL stale_after_reset[%0d]: got %b%b%b, required 000",
                         k, if_f.res_valid, if_r.res_valid, if_w.res_valid);
            end
            tick();
        end
        send(3, 8'h40, 8'h40);
        drain();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_arith();
        test_sparse();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mfp_mul_sched.md
# mfp_mul_sched

Round-robin scheduler that shares one pipelined signed fixed-point multiplier among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one request per cycle and pushes it through an `LAT`-stage multiply/round pipeline. It returns the product tagged with the requester index on a single result port with backpressure. It sits between filter/kernel engines and the shared multiplier resource, replacing per-engine multipliers.

## Interface
- `NREQ`, 4, number of requesters (2..16)
- `In1W`, 8, operand A width (signed two's complement)
- `In2W`, 8, operand B width (signed two's complement)
- `OutW`, 8, result width; must be < In1W+In2W-1
- `LAT`, 2, pipeline depth from grant to result valid (1..8)
- `isFloor`, 1, 1 = truncate; 0 = round half-up on the first dropped bit
- `Saturate`, 0, 1 = symmetric saturation when rounding (isFloor=0 only)
- `IDW`, clog2(NREQ), width of the result tag
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `req_valid` in NREQ: request i present
- `req_ready` out NREQ: request i accepted this cycle (one-hot or zero)
- `req_a` in NREQ*In1W: operand A, requester i at [i*In1W +: In1W]
- `req_b` in NREQ*In2W: operand B, requester i at [i*In2W +: In2W]
- `res_valid` out 1: result present
- `res_ready` in 1: result consumer accepts
- `res_id` out IDW: requester index of the result
- `res_data` out OutW: rounded product
- `busy` out 1: any pipeline stage holds a valid entry

## Operation
- **Advance condition:** `adv = !res_valid || res_ready`. When adv=0, every stage holds (global stall) and no grant is issued.
- **Grant:**
  - Only when adv=1 and |req_valid.
  - Search starts at index `(last+1) mod NREQ` and wraps.
  - The first valid index wins; `req_ready[win]=1` combinationally in the same cycle.
  - `last` is updated to `win` on the grant edge.
  - `last` resets to NREQ-1, so index 0 has first priority after reset.
- **Handshake:** a transfer occurs on a clock edge with `req_valid[i] && req_ready[i]`. Requesters must hold operands stable while valid and not ready. `req_ready` never depends on `res_data`.
- **Pipeline:**
  - Stage 0 captures {valid, id, a, b} on grant.
  - The product and rounding are computed across stages 1..LAT-1. Register placement is free provided total latency is exactly LAT with no stalls.
  - The final stage drives the `res_*` outputs.
- **Arithmetic:**
  - Let P = signed(a)*signed(b). Keep the low RW = In1W+In2W-1 bits (duplicate sign bit dropped).
  - Only -2^(In1W-1) * -2^(In2W-1) wraps; that case is defined as wrapping.
  - Floor: `res_data = P[RW-1 -: OutW]`.
  - Round: `T = P[RW-1 -: OutW] + P[RW-OutW-1]`, taken modulo 2^OutW.
  - Saturate=1 with isFloor=0: if the add overflows positive, or T equals -2^(OutW-1), the output is +/-(2^(OutW-1)-1), carrying the sign of the truncated value.
- **Ordering:** results leave in grant order. No reordering and no drops.

## Timing
- **Reset (rst_n=0, async):**
  - all stage valids = 0, `res_valid=0`, `res_id=0`, `res_data=0`
  - `busy=0`, `last=NREQ-1`
  - `req_ready=0` while reset is asserted
- **Latency:** a request granted at edge k gives `res_valid=1` after edge k+LAT, provided no stall occurs in between.
- **Throughput:** one result per cycle with `res_ready` held high.
- **Stall:** with `res_valid=1` and `res_ready=0`, all outputs hold and `req_ready=0`. The pipeline resumes on the first cycle `res_ready=1`, and that same cycle can grant a new request.
- **Simultaneous retire/accept:** retiring the final stage and granting into stage 0 in the same cycle is legal. Occupancy is unchanged.
- **Reset mid-operation:** all in-flight entries are discarded. Nothing is emitted after reset deasserts until a new grant plus LAT cycles.
- **busy:** the OR of all stage valids, registered.

## Test plan
- **Round-robin fairness.** NREQ=4, LAT=2, all four `req_valid` high continuously, `res_ready`=1.
  - Required grant order: 0,1,2,3,0,...
  - `res_id` must follow the same order, starting 2 cycles after the first grant.
- **Arithmetic, floor (In/Out=8, isFloor=1):**
  - a=0x40, b=0x40 -> 0x20
  - a=0x7F, b=0x7F -> 0x7E
  - a=0x01, b=0x40 -> 0x00
- **Rounding (isFloor=0, Saturate=1):**
  - a=0x01, b=0x40 -> 0x01
  - a=0x80, b=0x80 -> 0x81
  - Same pair with Saturate=0 -> 0x80
- **Backpressure.** Hold `res_ready`=0 for 5 cycles with req 2 pending.
  - `res_*` must stay frozen and `req_ready` must stay 0.
  - On release, all results must arrive in order, with no loss and no duplicates.
- **Sparse and priority-rotation requests.**
  - Only req 3 valid: grant occurs every cycle.
  - Then req 1 and req 3 valid with last=3: req 1 wins, then req 3.
- **Async reset mid-stream.**
  - Assert `rst_n`=0 between edges while 2 entries are in flight.
  - Outputs must go to reset values immediately.
  - After release, no stale `res_valid` may appear.
